// File: rtl/ps2_kbd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_decoder
// Description : Scan-code-set-2 decoder; folds E0/F0/E1 prefixes into key
//               events, tracks modifiers/Caps Lock, splits device responses.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_decoder #(
    parameter int SYSCLK     = 50,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_data,
    input  logic       byte_empty,
    output logic       byte_read,
    output logic       key_vld,
    input  logic       key_rdy,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    output logic       key_pause,
    output logic [6:0] mods,
    output logic       resp_vld,
    output logic [7:0] resp_data,
    output logic       seq_err
);

    localparam int c_TMO_CYC = SYSCLK * TIMEOUT_US;
    localparam int c_CNT_W   = $clog2(c_TMO_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_TMO_CYC - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_EXT   = 3'd1;
    localparam logic [2:0] c_BRK   = 3'd2;
    localparam logic [2:0] c_PAUSE = 3'd3;
    localparam logic [2:0] c_EMIT  = 3'd4;

    localparam logic [7:0] c_B_E0    = 8'hE0;
    localparam logic [7:0] c_B_E1    = 8'hE1;
    localparam logic [7:0] c_B_F0    = 8'hF0;
    localparam logic [7:0] c_B_LSH   = 8'h12;
    localparam logic [7:0] c_B_RSH   = 8'h59;
    localparam logic [7:0] c_B_CTRL  = 8'h14;
    localparam logic [7:0] c_B_ALT   = 8'h11;
    localparam logic [7:0] c_B_CAPS  = 8'h58;
    localparam logic [7:0] c_B_PAUSE = 8'h77;

    logic [2:0]         r_state, w_state_nxt;
    logic               r_ext, w_ext_nxt;
    logic [2:0]         r_pcnt, w_pcnt_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_pop, w_seq, w_timeout;
    logic               w_is_resp, w_is_bad, w_is_fake;
    logic               w_load, w_ld_ext, w_ld_brk, w_ld_pause;
    logic [7:0]         w_ld_code;
    logic               w_resp, w_err;

    logic [7:0]         r_key_code, r_resp_data;
    logic               r_key_ext, r_key_brk, r_key_pause;
    logic               r_resp_vld, r_seq_err;
    logic [6:0]         r_mods;
    logic               r_caps_down;

    assign w_is_bad  = (byte_data == 8'h00) || (byte_data == 8'hFF);
    assign w_is_resp = w_is_bad || (byte_data == 8'hFA) || (byte_data == 8'hFE) ||
                       (byte_data == 8'hEE) || (byte_data == 8'hAA);
    assign w_is_fake = (byte_data == c_B_LSH) || (byte_data == c_B_RSH);
    assign w_seq     = (r_state == c_EXT) || (r_state == c_BRK) || (r_state == c_PAUSE);
    // A byte arriving on the terminal-count cycle wins over the timeout.
    assign w_timeout = w_seq && !w_pop && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_ext   <= 1'b0;
            r_pcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ext   <= w_ext_nxt;
            r_pcnt  <= w_pcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ext_nxt   = r_ext;
        w_pcnt_nxt  = r_pcnt;
        w_load      = 1'b0;
        w_ld_code   = byte_data;
        w_ld_ext    = 1'b0;
        w_ld_brk    = 1'b0;
        w_ld_pause  = 1'b0;
        w_resp      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_pop) begin
                    if (byte_data == c_B_E0) begin
                        w_state_nxt = c_EXT;
                    end else if (byte_data == c_B_F0) begin
                        w_state_nxt = c_BRK;
                        w_ext_nxt   = 1'b0;
                    end else if (byte_data == c_B_E1) begin
                        w_state_nxt = c_PAUSE;
                        w_pcnt_nxt  = 3'd1;
                    end else if (w_is_resp) begin
                        w_resp = 1'b1;
                    end else begin
                        w_state_nxt = c_EMIT;
                        w_load      = 1'b1;
                    end
                end
            end
            c_EXT: begin
                if (w_timeout) begin
                    w_state_nxt = c_IDLE;
                    w_err       = 1'b1;
                end else if (w_pop) begin
                    if (byte_data == c_B_F0) begin
                        w_state_nxt = c_BRK;
                        w_ext_nxt   = 1'b1;
                    end else if (w_is_fake) begin
                        w_state_nxt = c_IDLE;
                    end else if (w_is_bad) begin
                        w_state_nxt = c_IDLE;
                        w_err       = 1'b1;
                        w_resp      = 1'b1;
                    end else if (byte_data != c_B_E0) begin
                        w_state_nxt = c_EMIT;
                        w_load      = 1'b1;
                        w_ld_ext    = 1'b1;
                    end
                end
            end
            c_BRK: begin
                if (w_timeout) begin
                    w_state_nxt = c_IDLE;
                    w_err       = 1'b1;
                end else if (w_pop) begin
                    if (w_is_fake && r_ext) begin
                        w_state_nxt = c_IDLE;
                    end else if (w_is_bad) begin
                        w_state_nxt = c_IDLE;
                        w_err       = 1'b1;
                        w_resp      = 1'b1;
                    end else begin
                        w_state_nxt = c_EMIT;
                        w_load      = 1'b1;
                        w_ld_ext    = r_ext;
                        w_ld_brk    = 1'b1;
                    end
                end
            end
            c_PAUSE: begin
                if (w_timeout) begin
                    w_state_nxt = c_IDLE;
                    w_pcnt_nxt  = 3'd0;
                    w_err       = 1'b1;
                end else if (w_pop) begin
                    if (r_pcnt == 3'd7) begin
                        w_state_nxt = c_EMIT;
                        w_pcnt_nxt  = 3'd0;
                        w_load      = 1'b1;
                        w_ld_code   = c_B_PAUSE;
                        w_ld_pause  = 1'b1;
                    end else begin
                        w_pcnt_nxt = r_pcnt + 3'd1;
                    end
                end
            end
            c_EMIT: begin
                if (key_rdy) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_pop   = rst && !byte_empty && (r_state != c_EMIT);
        key_vld = (r_state == c_EMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_key_code  <= 8'h00;
            r_key_ext   <= 1'b0;
            r_key_brk   <= 1'b0;
            r_key_pause <= 1'b0;
            r_resp_vld  <= 1'b0;
            r_resp_data <= 8'h00;
            r_seq_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_load) begin
                r_key_code  <= w_ld_code;
                r_key_ext   <= w_ld_ext;
                r_key_brk   <= w_ld_brk;
                r_key_pause <= w_ld_pause;
            end
            r_resp_vld <= w_resp;
            if (w_resp) begin
                r_resp_data <= byte_data;
            end
            r_seq_err <= w_err;
            if (w_pop || !w_seq || w_timeout) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    // Modifier bits: {caps, ralt, lalt, rctrl, lctrl, rshift, lshift}.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mods      <= 7'd0;
            r_caps_down <= 1'b0;
        end else if (w_load && !w_ld_pause) begin
            case (w_ld_code)
                c_B_LSH:  if (!w_ld_ext) r_mods[0] <= !w_ld_brk;
                c_B_RSH:  if (!w_ld_ext) r_mods[1] <= !w_ld_brk;
                c_B_CTRL: if (w_ld_ext) r_mods[3] <= !w_ld_brk;
                          else          r_mods[2] <= !w_ld_brk;
                c_B_ALT:  if (w_ld_ext) r_mods[5] <= !w_ld_brk;
                          else          r_mods[4] <= !w_ld_brk;
                c_B_CAPS: begin
                    // Typematic repeats arrive as makes while held; only the first toggles.
                    if (!w_ld_ext) begin
                        if (w_ld_brk) begin
                            r_caps_down <= 1'b0;
                        end else if (!r_caps_down) begin
                            r_mods[6]   <= !r_mods[6];
                            r_caps_down <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_read = w_pop;
    assign key_code  = r_key_code;
    assign key_ext   = r_key_ext;
    assign key_brk   = r_key_brk;
    assign key_pause = r_key_pause;
    assign mods      = r_mods;
    assign resp_vld  = r_resp_vld;
    assign resp_data = r_resp_data;
    assign seq_err   = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_kbd_decoder
// Description : Directed self-checking bench for ps2_kbd_decoder with a
//               byte FIFO model and event/response monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_decoder;

    localparam int c_SYSCLK = 1;
    localparam int c_TMO_US = 20;
    localparam int c_TMO    = c_SYSCLK * c_TMO_US;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] byte_data;
    logic       byte_empty;
    logic       byte_read;
    logic       key_vld;
    logic       key_rdy = 1'b1;
    logic [7:0] key_code;
    logic       key_ext, key_brk, key_pause;
    logic [6:0] mods;
    logic       resp_vld;
    logic [7:0] resp_data;
    logic       seq_err;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_kbd_decoder #(
        .SYSCLK     (c_SYSCLK),
        .TIMEOUT_US (c_TMO_US)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_data  (byte_data),
        .byte_empty (byte_empty),
        .byte_read  (byte_read),
        .key_vld    (key_vld),
        .key_rdy    (key_rdy),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_brk    (key_brk),
        .key_pause  (key_pause),
        .mods       (mods),
        .resp_vld   (resp_vld),
        .resp_data  (resp_data),
        .seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    // FWFT byte FIFO feeding the decoder
    logic [7:0] fifo_mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    assign byte_empty = (rd_ptr == wr_ptr);
    assign byte_data  = fifo_mem[rd_ptr];
    always @(posedge clk) if (byte_read) rd_ptr <= rd_ptr + 8'd1;

    // Monitors: event record = {mods, pause, brk, ext, code}
    int          cyc = 0;
    int          last_pop = 0;
    int          run_len = 0;
    int          err_n = 0;
    int          err_cyc = 0;
    logic        vld_d = 1'b0;
    logic [17:0] ev_q[$];
    int          len_q[$];
    int          lat_q[$];
    logic [7:0]  resp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_read) last_pop <= cyc;
        if (key_vld && !vld_d) lat_q.push_back(cyc - last_pop);
        if (key_vld) run_len <= run_len + 1;
        else if (run_len != 0) begin
            len_q.push_back(run_len);
            run_len <= 0;
        end
        if (key_vld && key_rdy) ev_q.push_back({mods, key_pause, key_brk, key_ext, key_code});
        if (resp_vld) resp_q.push_back(resp_data);
        if (seq_err) begin
            err_n   <= err_n + 1;
            err_cyc <= cyc;
        end
        vld_d <= key_vld;
    end

    int ev0 = 0, rs0 = 0, ln0 = 0, lt0 = 0, er0 = 0;

    task automatic mark();
        ev0 = ev_q.size();
        rs0 = resp_q.size();
        ln0 = len_q.size();
        lt0 = lat_q.size();
        er0 = err_n;
    endtask

    function automatic logic [17:0] ev(input logic [6:0] m, input logic p, input logic b,
                                       input logic e, input logic [7:0] c);
        return {m, p, b, e, c};
    endfunction

    function automatic logic [17:0] ev_at(input int i);
        if (ev0 + i < ev_q.size()) return ev_q[ev0 + i];
        return 18'h3FFFF;
    endfunction

    function automatic int len_at(input int i);
        if (ln0 + i < len_q.size()) return len_q[ln0 + i];
        return -1;
    endfunction

    function automatic int lat_at(input int i);
        if (lt0 + i < lat_q.size()) return lat_q[lt0 + i];
        return -1;
    endfunction

    function automatic int resp_at(input int i);
        if (rs0 + i < resp_q.size()) return int'(resp_q[rs0 + i]);
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic wait_vld(input string tag, input int max);
        int n;
        n = 0;
        while (!key_vld && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, key_vld, 1);
    endtask

    initial begin
        int bad;

        // Reset state
        step(3);
        @(negedge clk);
        check("rst_vld",   key_vld, 0);
        check("rst_read",  byte_read, 0);
        check("rst_mods",  mods, 0);
        check("rst_resp",  resp_vld, 0);
        check("rst_err",   seq_err, 0);
        check("rst_code",  key_code, 0);
        @(posedge clk); #2 rst = 1'b1;

        // Plain make then break, consumer always ready
        mark();
        push(8'h1C); push(8'hF0); push(8'h1C);
        step(20);
        check("t1_count", ev_q.size() - ev0, 2);
        check("t1_make",  ev_at(0), ev(7'h00, 0, 0, 0, 8'h1C));
        check("t1_break", ev_at(1), ev(7'h00, 0, 1, 0, 8'h1C));
        check("t1_len0",  len_at(0), 1);
        check("t1_len1",  len_at(1), 1);
        check("t1_lat0",  lat_at(0), 1);
        check("t1_lat1",  lat_at(1), 1);

        // Extended break held by backpressure, another byte waiting
        key_rdy = 1'b0;
        mark();
        push(8'hE0); push(8'hF0); push(8'h75); push(8'h1C);
        wait_vld("t2_wait", 20);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!(key_vld === 1'b1 && key_code === 8'h75 && key_ext === 1'b1 &&
                  key_brk === 1'b1 && key_pause === 1'b0 && byte_read === 1'b0)) bad++;
        end
        check("t2_hold", bad, 0);
        @(posedge clk); #2 key_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t2_vld_drop", key_vld, 0);
        check("t2_next_pop", byte_read, 1);
        step(10);
        check("t2_count", ev_q.size() - ev0, 2);
        check("t2_ev0",   ev_at(0), ev(7'h00, 0, 1, 1, 8'h75));
        check("t2_ev1",   ev_at(1), ev(7'h00, 0, 0, 0, 8'h1C));
        check("t2_len",   len_at(0) >= 11, 1);

        // Modifiers and Caps Lock with typematic repeat
        mark();
        push(8'h12); push(8'hE0); push(8'h14); push(8'h58); push(8'h58);
        push(8'hF0); push(8'h58); push(8'h58);
        step(30);
        check("t3_count", ev_q.size() - ev0, 6);
        check("t3_lshift", ev_at(0), ev(7'h01, 0, 0, 0, 8'h12));
        check("t3_rctrl",  ev_at(1), ev(7'h09, 0, 0, 1, 8'h14));
        check("t3_caps1",  ev_at(2), ev(7'h49, 0, 0, 0, 8'h58));
        check("t3_caps_rp", ev_at(3), ev(7'h49, 0, 0, 0, 8'h58));
        check("t3_caps_br", ev_at(4), ev(7'h49, 0, 1, 0, 8'h58));
        check("t3_caps2",  ev_at(5), ev(7'h09, 0, 0, 0, 8'h58));
        check("t3_mods",   mods, 7'h09);

        rst = 1'b0;
        step(2);
        rst = 1'b1;
        check("t4_mods_rst", mods, 0);

        // Print Screen make/break with fake shifts
        mark();
        push(8'hE0); push(8'h12); push(8'hE0); push(8'h7C);
        push(8'hE0); push(8'hF0); push(8'h7C); push(8'hE0); push(8'hF0); push(8'h12);
        step(30);
        check("t4_count", ev_q.size() - ev0, 2);
        check("t4_make",  ev_at(0), ev(7'h00, 0, 0, 1, 8'h7C));
        check("t4_break", ev_at(1), ev(7'h00, 0, 1, 1, 8'h7C));
        check("t4_mods",  mods, 0);
        check("t4_err",   err_n - er0, 0);

        // Pause sequence followed by device responses
        mark();
        push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
        push(8'hF0); push(8'h14); push(8'hF0); push(8'h77);
        push(8'hFA); push(8'hAA);
        step(30);
        check("t5_count", ev_q.size() - ev0, 1);
        check("t5_pause", ev_at(0), ev(7'h00, 1, 0, 0, 8'h77));
        check("t5_nresp", resp_q.size() - rs0, 2);
        check("t5_resp0", resp_at(0), 32'hFA);
        check("t5_resp1", resp_at(1), 32'hAA);
        check("t5_err",   err_n - er0, 0);

        // 00 inside an E0 sequence aborts it
        mark();
        push(8'hE0); push(8'h00);
        step(10);
        check("t6_bad_ev",   ev_q.size() - ev0, 0);
        check("t6_bad_err",  err_n - er0, 1);
        check("t6_bad_nrsp", resp_q.size() - rs0, 1);
        check("t6_bad_resp", resp_at(0), 32'h00);

        // Timeout after E0, then a plain key
        mark();
        push(8'hE0);
        step(40);
        check("t6_tmo_err", err_n - er0, 1);
        check("t6_tmo_lat", err_cyc - last_pop, c_TMO + 1);
        check("t6_tmo_ev",  ev_q.size() - ev0, 0);
        push(8'h1C);
        step(10);
        check("t6_after", ev_at(0), ev(7'h00, 0, 0, 0, 8'h1C));

        // Gap shorter than the timeout keeps the sequence
        mark();
        push(8'hE0);
        step(15);
        push(8'h1C);
        step(10);
        check("t6_short_ev",  ev_at(0), ev(7'h00, 0, 0, 1, 8'h1C));
        check("t6_short_err", err_n - er0, 0);

        // Reset while in BRK with a byte waiting
        mark();
        push(8'hF0);
        step(3);
        rst = 1'b0;
        push(8'h1C);
        @(negedge clk);
        check("t7_no_pop", byte_read, 0);
        @(negedge clk);
        check("t7_vld",   key_vld, 0);
        check("t7_code",  key_code, 0);
        check("t7_flags", {key_ext, key_brk, key_pause}, 0);
        check("t7_resp",  {resp_vld, seq_err, resp_data}, 0);
        check("t7_read",  byte_read, 0);
        @(posedge clk); #2 rst = 1'b1;
        step(10);
        check("t7_count", ev_q.size() - ev0, 1);
        check("t7_ev",    ev_at(0), ev(7'h00, 0, 0, 0, 8'h1C));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
